// File: rtl/onehot_select_sequencer_if.sv
// Request/response bundle for onehot_select_sequencer: valid/ready request side plus
// the registered one-hot select outputs and status pulses.
interface onehot_select_sequencer_if #(
    parameter int ADDR_W  = 5,
    parameter int NUM_OUT = 18
);
    logic              en;
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W:0]   len_in;
    logic [NUM_OUT-1:0] y;
    logic [ADDR_W-1:0] y_idx;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output en, mode, in_valid, addr_in, len_in,
        input  in_ready, y, y_idx, busy, done, err
    );

    modport slave (
        input  en, mode, in_valid, addr_in, len_in,
        output in_ready, y, y_idx, busy, done, err
    );
endinterface

// File: rtl/onehot_select_sequencer.sv
// Registered one-hot write-select sequencer: DIRECT decodes one address, BURST walks
// consecutive targets one per enabled cycle, wrapping at NUM_OUT.
module onehot_select_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int NUM_OUT = 18
) (
    input logic clk,
    input logic rst,
    onehot_select_sequencer_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [ADDR_W:0]   NUM_OUT_W = (ADDR_W+1)'(NUM_OUT);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_OUT - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  ptr, ptr_n;
    logic [ADDR_W:0]    cnt, cnt_n;
    logic [NUM_OUT-1:0] y_n;
    logic [ADDR_W-1:0]  y_idx_n;
    logic               busy_n, done_n, err_n;
    logic               accept, illegal;

    function automatic logic [NUM_OUT-1:0] decode(input logic [ADDR_W-1:0] a);
        logic [NUM_OUT-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) v[i] = (a == ADDR_W'(i));
        return v;
    endfunction

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign bus.in_ready = bus.en & (state == IDLE);
    assign accept       = bus.in_valid & bus.in_ready;
    assign illegal      = ({1'b0, bus.addr_in} >= NUM_OUT_W) |
                          (bus.mode & (bus.len_in > NUM_OUT_W));

    // First burst select is emitted from addr_in at the accept edge, so ptr/cnt then
    // track the select after the one currently on y and the count still to emit.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        y_n     = '0;
        y_idx_n = '0;
        busy_n  = (state == BURST);
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        err_n = 1'b1;
                    end else if (!bus.mode) begin
                        y_n     = decode(bus.addr_in);
                        y_idx_n = bus.addr_in;
                        done_n  = 1'b1;
                    end else if (bus.len_in == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = BURST;
                        busy_n  = 1'b1;
                        y_n     = decode(bus.addr_in);
                        y_idx_n = bus.addr_in;
                        done_n  = (bus.len_in == CNT_ONE);
                        ptr_n   = next_ptr(bus.addr_in);
                        cnt_n   = bus.len_in - 1'b1;
                    end
                end
            end
            BURST: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    ptr_n   = '0;
                end else if (bus.en) begin
                    y_n     = decode(ptr);
                    y_idx_n = ptr;
                    done_n  = (cnt == CNT_ONE);
                    ptr_n   = next_ptr(ptr);
                    cnt_n   = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            bus.y     <= '0;
            bus.y_idx <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            bus.y     <= y_n;
            bus.y_idx <= y_idx_n;
            bus.busy  <= busy_n;
            bus.done  <= done_n;
            bus.err   <= err_n;
        end
    end
endmodule

// File: tb/tb_onehot_select_sequencer.sv
// Bench for onehot_select_sequencer: directed scenarios plus random traffic, all checked
// against a queue-based model of the select sequence.
module tb_onehot_select_sequencer;
    localparam int AW = 5;
    localparam int N  = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    onehot_select_sequencer_if #(.ADDR_W(AW), .NUM_OUT(N)) bus ();

    onehot_select_sequencer #(.ADDR_W(AW), .NUM_OUT(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: pending burst targets as a queue of indices, busy while a burst is open.
    int q[$];
    bit m_busy = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit e, input bit v, input bit m, input int a, input int l);
        bit         ready;
        bit [N-1:0] ey;
        int         eidx;
        bit         edone, eerr;
        int         idx;
        bus.en       = e;
        bus.in_valid = v;
        bus.mode     = m;
        bus.addr_in  = a[AW-1:0];
        bus.len_in   = l[AW:0];
        #1;
        ready = e && !m_busy;
        check("in_ready", {63'b0, bus.in_ready}, {63'b0, ready});
        ey = '0; eidx = 0; edone = 0; eerr = 0;
        if (m_busy) begin
            if (q.size() == 0) begin
                m_busy = 1'b0;
            end else if (e) begin
                idx = q.pop_front();
                ey[idx] = 1'b1; eidx = idx;
                edone = (q.size() == 0);
            end
        end else if (ready && v) begin
            if (a >= N || (m && l > N)) begin
                eerr = 1'b1;
            end else if (!m) begin
                ey[a] = 1'b1; eidx = a; edone = 1'b1;
            end else if (l == 0) begin
                edone = 1'b1;
            end else begin
                for (int i = 0; i < l; i++) q.push_back((a + i) % N);
                m_busy = 1'b1;
                idx = q.pop_front();
                ey[idx] = 1'b1; eidx = idx;
                edone = (q.size() == 0);
            end
        end
        @(posedge clk);
        #1;
        check("y",      64'(bus.y),     64'(ey));
        check("y_idx",  64'(bus.y_idx), 64'(eidx));
        check("done",   64'(bus.done),  64'(edone));
        check("err",    64'(bus.err),   64'(eerr));
        check("busy",   64'(bus.busy),  64'(m_busy));
        check("onehot", 64'($countones(bus.y) <= 1), 64'(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    initial begin
        int a, l;
        bit e, v, m;
        rst = 1'b1;
        bus.en = 1'b0; bus.in_valid = 1'b0; bus.mode = 1'b0;
        bus.addr_in = '0; bus.len_in = '0;
        #12;
        check("rst_y",     64'(bus.y),     64'(0));
        check("rst_y_idx", 64'(bus.y_idx), 64'(0));
        check("rst_busy",  64'(bus.busy),  64'(0));
        check("rst_done",  64'(bus.done),  64'(0));
        check("rst_err",   64'(bus.err),   64'(0));
        @(negedge clk);
        rst = 1'b0;

        // DIRECT back-to-back
        step(1, 1, 0, 0, 0); step(1, 1, 0, 5, 0); step(1, 1, 0, 17, 0);
        idle(2);
        // BURST with wrap; request held during burst must wait
        step(1, 1, 1, 16, 4);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 3, 0);
        idle(2);
        // illegal requests
        step(1, 1, 0, 18, 0); step(1, 1, 1, 3, 19); step(1, 1, 1, 31, 2);
        idle(1);
        // en gaps mid-burst
        step(1, 1, 1, 2, 5);
        step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        // en low in IDLE holds off a pending request
        step(0, 1, 0, 4, 0); step(0, 1, 0, 4, 0); step(1, 1, 0, 4, 0);
        idle(1);
        // async reset mid-burst
        step(1, 1, 1, 8, 10); step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_y",    64'(bus.y),    64'(0));
        check("arst_busy", 64'(bus.busy), 64'(0));
        check("arst_done", 64'(bus.done), 64'(0));
        q.delete();
        m_busy = 1'b0;
        #1 rst = 1'b0;
        step(1, 1, 0, 9, 0);
        idle(1);
        // zero-length and full-length bursts
        step(1, 1, 1, 7, 0); step(1, 1, 1, 0, 1); step(1, 1, 1, 17, N);
        idle(N + 2);

        for (int i = 0; i < 800; i++) begin
            e = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 3) != 0);
            m = $urandom_range(0, 1);
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(N, 31) : $urandom_range(0, N - 1);
            l = ($urandom_range(0, 9) == 0) ? $urandom_range(N + 1, 31) : $urandom_range(0, N);
            step(e, v, m, a, l);
        end
        idle(N + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1);
    end
endmodule
